// File: rtl/alu_cond_writeback_stage.sv
// ALU writeback stage: evaluates the ARM condition against the committed NZCV
// register, optionally commits new flags, and queues results in a 2-entry skid buffer.
module alu_cond_writeback_stage #(
    parameter int BITS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [BITS-1:0] result_i,
    input  logic [3:0]      flags_i,
    input  logic [3:0]      cond_i,
    input  logic            set_flags_i,
    input  logic            we_req_i,
    input  logic [3:0]      dst_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [BITS-1:0] out_data_o,
    output logic [3:0]      out_dst_o,
    output logic            out_we_o,
    output logic [3:0]      nzcv_o
);
    localparam int DEPTH = 2;
    localparam int EW    = BITS + 5;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [EW-1:0] head_q, head_d;
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [3:0]    nzcv_q, nzcv_d;
    logic          full, push, pop, pass;

    // Flag bit order: [0]=N [1]=Z [2]=C [3]=V. Odd codes invert their even partner.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[0];
        z = f[1];
        c = f[2];
        v = f[3];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond == 4'hF) ? 1'b0 : (base ^ cond[0]);
    endfunction

    always_comb begin
        full     = (count_q == 2'(DEPTH));
        push     = in_valid_i & ~full;
        pop      = (count_q != 2'd0) & out_ready_i;
        pass     = cond_pass(cond_i, nzcv_q);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        nzcv_d   = nzcv_q;
        head_d   = head_q;
        if (push) begin
            mem_d[wr_ptr_q] = {result_i, dst_i, we_req_i & pass};
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push && pass && set_flags_i) begin
            nzcv_d = flags_i;
        end
        // Output word is re-registered so OUT_* hold their last value once empty.
        if (count_d != 2'd0) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q   <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            nzcv_q   <= 4'b0000;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            nzcv_q   <= nzcv_d;
        end
    end

    assign in_ready_o  = (count_q != 2'(DEPTH));
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q[EW-1:5];
    assign out_dst_o   = head_q[4:1];
    assign out_we_o    = head_q[0];
    assign nzcv_o      = nzcv_q;

endmodule

// File: tb/tb_alu_cond_writeback_stage.sv
// Directed bench with a scoreboard queue and a reference NZCV/occupancy model.
module tb_alu_cond_writeback_stage;
    localparam int BITS = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] result;
    logic [3:0]      flags;
    logic [3:0]      cond;
    logic            set_flags;
    logic            we_req;
    logic [3:0]      dst;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;
    logic [3:0]      out_dst;
    logic            out_we;
    logic [3:0]      nzcv;

    typedef struct {
        logic [BITS-1:0] data;
        logic [3:0]      dst;
        logic            we;
    } entry_t;

    entry_t     sb_q[$];
    int         model_count = 0;
    logic [3:0] model_nzcv  = 4'b0000;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    alu_cond_writeback_stage #(.BITS(BITS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_i    (result),
        .flags_i     (flags),
        .cond_i      (cond),
        .set_flags_i (set_flags),
        .we_req_i    (we_req),
        .dst_i       (dst),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_dst_o   (out_dst),
        .out_we_o    (out_we),
        .nzcv_o      (nzcv)
    );

    // Reference condition table written out per code.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[0]; z = f[1]; cy = f[2]; v = f[3];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: called at negedge, drives inputs, checks outputs, updates model, advances.
    task automatic cycle(input logic v, input logic [BITS-1:0] res, input logic [3:0] fl,
                         input logic [3:0] cd, input logic sf, input logic we,
                         input logic [3:0] d, input logic ordy);
        logic   push, pop, p;
        entry_t e;
        in_valid = v; result = res; flags = fl; cond = cd;
        set_flags = sf; we_req = we; dst = d; out_ready = ordy;
        #1;
        check("in_ready", 64'(in_ready), 64'(model_count != 2));
        check("out_valid", 64'(out_valid), 64'(model_count != 0));
        if (model_count != 0) begin
            check("out_data", 64'(out_data), 64'(sb_q[0].data));
            check("out_dst", 64'(out_dst), 64'(sb_q[0].dst));
            check("out_we", 64'(out_we), 64'(sb_q[0].we));
        end
        push = v && (model_count != 2);
        pop  = (model_count != 0) && ordy;
        p    = ref_pass(cd, model_nzcv);
        if (pop) void'(sb_q.pop_front());
        if (push) begin
            e.data = res; e.dst = d; e.we = we && p;
            sb_q.push_back(e);
            if (p && sf) model_nzcv = fl;
        end
        model_count = model_count + int'(push) - int'(pop);
        $display("txn t=%0t v=%0b res=%0h cond=%0h push=%0b pop=%0b pass=%0b count=%0d",
                 $time, v, res, cd, push, pop, p, model_count);
        @(posedge clk);
        @(negedge clk);
        check("nzcv", 64'(nzcv), 64'(model_nzcv));
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 4'h0, 4'hE, 1'b0, 1'b0, 4'h0, ordy);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; result = '0; flags = '0; cond = '0;
        set_flags = 1'b0; we_req = 1'b0; dst = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_nzcv", 64'(nzcv), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_dst", 64'(out_dst), 64'd0);
        check("rst_out_we", 64'(out_we), 64'd0);
        rst_n = 1'b1;

        // First accept after reset: AL with flag commit
        cycle(1'b1, 32'h0, 4'b0010, 4'hE, 1'b1, 1'b1, 4'd3, 1'b1);
        check("first_nzcv", 64'(nzcv), 64'h2);
        idle(1'b1);

        // EQ then NE under Z=1, no flag update
        cycle(1'b1, 32'hA, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd5, 1'b1);
        cycle(1'b1, 32'hB, 4'b0000, 4'h1, 1'b0, 1'b1, 4'd6, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Back-to-back flag dependency: commit C, then CS must see it
        cycle(1'b1, 32'hC0, 4'b0100, 4'hE, 1'b1, 1'b1, 4'd1, 1'b1);
        cycle(1'b1, 32'hC1, 4'b0000, 4'h2, 1'b0, 1'b1, 4'd2, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: fill, hold third, then drain
        cycle(1'b1, 32'h11, 4'h0, 4'hE, 1'b0, 1'b1, 4'd1, 1'b0);
        cycle(1'b1, 32'h22, 4'h0, 4'hE, 1'b0, 1'b1, 4'd2, 1'b0);
        cycle(1'b1, 32'h33, 4'hF, 4'hE, 1'b1, 1'b1, 4'd3, 1'b0);
        cycle(1'b1, 32'h33, 4'hF, 4'hE, 1'b1, 1'b1, 4'd3, 1'b1);
        cycle(1'b1, 32'h33, 4'h0, 4'hE, 1'b0, 1'b1, 4'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Full condition sweep over every committed NZCV value
        for (int nz = 0; nz < 16; nz++) begin
            for (int c = 0; c < 16; c++) begin
                cycle(1'b1, 32'hFFFF, 4'(nz), 4'hE, 1'b1, 1'b0, 4'd0, 1'b1);
                cycle(1'b1, 32'(nz * 16 + c), 4'($urandom_range(0, 15)), 4'(c),
                      1'b1, 1'b1, 4'(c), 1'b1);
            end
        end
        idle(1'b1);
        idle(1'b1);

        // Async reset with two buffered entries
        cycle(1'b1, 32'h51, 4'b1001, 4'hE, 1'b1, 1'b1, 4'd7, 1'b0);
        cycle(1'b1, 32'h52, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd8, 1'b0);
        check("pre_rst_nzcv", 64'(nzcv), 64'h9);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_nzcv", 64'(nzcv), 64'd0);
        sb_q.delete();
        model_count = 0;
        model_nzcv  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // Steady push+pop at occupancy 1
        cycle(1'b1, 32'd0, 4'h0, 4'hE, 1'b0, 1'b1, 4'd9, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 32'(i), 4'h0, 4'hE, 1'b0, 1'b1, 4'd9, 1'b1);
            check("steady_count1", 64'(model_count), 64'd1);
        end
        idle(1'b1);
        idle(1'b1);
        check("drained", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
